// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and limits for the memory responder
package cpu_mem_pkg;

   // Responder FSM: IDLE services requests, CLEAR runs the bulk-zero engine
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } resp_state_t;

   // Deepest read pipeline the responder supports
   localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/mem_read_pipe.sv
// rtl/mem_read_pipe.sv - valid/data shift pipeline carrying read samples to the output
module mem_read_pipe #(
   parameter int STAGES     = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_flush,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign o_valid = i_valid;
         assign o_data  = i_data;
      end else begin : g_pipe
         logic                  r_valid [STAGES];
         logic [DATA_WIDTH-1:0] r_data  [STAGES];

         // Valid shifts every cycle; data only moves behind a valid so the last stage holds its value
         always_ff @(posedge clk) begin
            if (i_flush) begin
               for (int i = 0; i < STAGES; i++) begin
                  r_valid[i] <= 1'b0;
                  r_data[i]  <= '0;
               end
            end else begin
               r_valid[0] <= i_valid;
               if (i_valid) r_data[0] <= i_data;
               for (int i = 1; i < STAGES; i++) begin
                  r_valid[i] <= r_valid[i-1];
                  if (r_valid[i-1]) r_data[i] <= r_data[i-1];
               end
            end
         end

         assign o_valid = r_valid[STAGES-1];
         assign o_data  = r_data[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/custom_mem_responder.sv
// rtl/custom_mem_responder.sv - scratchpad responder with fixed-latency reads and bulk clear
module custom_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_read_enable,
   input  logic                  mem_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic                  clear_start,
   output logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  mem_read_valid,
   output logic                  mem_ready,
   output logic                  mem_error,
   output logic [31:0]           read_count,
   output logic [31:0]           write_count,
   output logic [31:0]           error_count
);

   // Latency kept inside the range the pipeline is built for
   localparam int LAT   = (READ_LATENCY < 1) ? 1 :
                          (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   resp_state_t           r_state;
   resp_state_t           w_state_next;
   logic [IDX_W-1:0]      r_clr_idx;
   logic                  r_ready;
   logic                  r_error;
   logic [31:0]           r_read_count;
   logic [31:0]           r_write_count;
   logic [31:0]           r_error_count;
   logic                  r_s1_valid;
   logic [DATA_WIDTH-1:0] r_s1_data;

   logic w_req;
   logic w_in_range;
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_err;
   logic w_clr_last;
   logic w_clr_we;

   // r_ready is low in the post-reset cycle and throughout CLEAR; it gates all acceptance
   assign w_req      = mem_read_enable | mem_write_enable;
   assign w_in_range = (32'(mem_addr) < DEPTH_U);
   assign w_wr_acc   = r_ready & mem_write_enable & w_in_range;
   assign w_rd_acc   = r_ready & mem_read_enable & ~mem_write_enable & w_in_range;
   assign w_err      = w_req & (~r_ready | ~w_in_range | (mem_read_enable & mem_write_enable));
   assign w_clr_last = (r_clr_idx == IDX_W'(DEPTH - 1));
   assign w_clr_we   = (r_state == ST_CLEAR) & ~rst;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state: clear_start only honoured in IDLE; CLEAR ends once the last entry is zeroed
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (clear_start) w_state_next = ST_CLEAR;
         ST_CLEAR: if (w_clr_last)  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Clear index walks 0..DEPTH-1 while clearing, parked at 0 otherwise
   always_ff @(posedge clk) begin
      if (rst || r_state != ST_CLEAR || w_clr_last) r_clr_idx <= '0;
      else                                          r_clr_idx <= r_clr_idx + 1'b1;
   end

   // Single write port shared by the clear engine and accepted writes; never reset
   always_ff @(posedge clk) begin
      if (w_clr_we)              r_mem[r_clr_idx] <= '0;
      else if (w_wr_acc && !rst) r_mem[mem_addr]  <= mem_write_data;
   end

   // Handshake, error pulse and statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready       <= 1'b0;
         r_error       <= 1'b0;
         r_read_count  <= '0;
         r_write_count <= '0;
         r_error_count <= '0;
      end else begin
         r_ready <= (w_state_next == ST_IDLE);
         r_error <= w_err;
         if (w_rd_acc) r_read_count  <= r_read_count + 32'd1;
         if (w_wr_acc) r_write_count <= r_write_count + 32'd1;
         if (w_err)    r_error_count <= r_error_count + 32'd1;
      end
   end

   // First read stage: sample the array at the request edge, before that edge's write lands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_rd_acc;
         if (w_rd_acc) r_s1_data <= r_mem[mem_addr];
      end
   end

   mem_read_pipe #(
      .STAGES     (LAT - 1),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_read_pipe (
      .clk     (clk),
      .i_flush (rst),
      .i_valid (r_s1_valid),
      .i_data  (r_s1_data),
      .o_valid (mem_read_valid),
      .o_data  (mem_read_data)
   );

   assign mem_ready   = r_ready;
   assign mem_error   = r_error;
   assign read_count  = r_read_count;
   assign write_count = r_write_count;
   assign error_count = r_error_count;

endmodule

// File: tb/tb_custom_mem_responder.sv
// tb/tb_custom_mem_responder.sv - directed self-checking bench for custom_mem_responder
module tb_custom_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mem_addr;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [7:0]  mem_write_data;
   logic        clear_start;
   logic [7:0]  mem_read_data;
   logic        mem_read_valid;
   logic        mem_ready;
   logic        mem_error;
   logic [31:0] read_count;
   logic [31:0] write_count;
   logic [31:0] error_count;

   int checks = 0;
   int errors = 0;
   int lowcnt;

   custom_mem_responder dut (
      .clk              (clk),
      .rst              (rst),
      .mem_addr         (mem_addr),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .clear_start      (clear_start),
      .mem_read_data    (mem_read_data),
      .mem_read_valid   (mem_read_valid),
      .mem_ready        (mem_ready),
      .mem_error        (mem_error),
      .read_count       (read_count),
      .write_count      (write_count),
      .error_count      (error_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      clear_start      = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      idle();
      mem_addr = a; mem_write_data = d; mem_write_enable = 1'b1;
      tick();
      idle();
   endtask

   task automatic rd_issue(input logic [7:0] a);
      idle();
      mem_addr = a; mem_read_enable = 1'b1;
   endtask

   initial begin
      rst = 1'b1; mem_addr = '0; mem_write_data = '0; idle();
      tick(); tick();
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_valid", 32'(mem_read_valid), 32'd0);
      chk("rst_error", 32'(mem_error), 32'd0);
      chk("rst_rdata", 32'(mem_read_data), 32'd0);
      chk("rst_rcnt", read_count, 32'd0);
      chk("rst_wcnt", write_count, 32'd0);
      chk("rst_ecnt", error_count, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 32'(mem_ready), 32'd1);

      // 1: write then read with latency 2
      wr(8'h10, 8'h5A);
      chk("t1_wcnt", write_count, 32'd1);
      chk("t1_werr", 32'(mem_error), 32'd0);
      rd_issue(8'h10); tick(); idle();
      chk("t1_valid_lat1", 32'(mem_read_valid), 32'd0);
      chk("t1_rcnt", read_count, 32'd1);
      tick();
      chk("t1_valid_lat2", 32'(mem_read_valid), 32'd1);
      chk("t1_data", 32'(mem_read_data), 32'h5A);
      tick();
      chk("t1_valid_drop", 32'(mem_read_valid), 32'd0);
      chk("t1_data_hold", 32'(mem_read_data), 32'h5A);

      // 2: back-to-back reads
      wr(8'h00, 8'h11); wr(8'h01, 8'h22); wr(8'h02, 8'h33); wr(8'h20, 8'h01);
      rd_issue(8'h00); tick();
      chk("t2_v0", 32'(mem_read_valid), 32'd0);
      rd_issue(8'h01); tick();
      chk("t2_v1", 32'(mem_read_valid), 32'd1);
      chk("t2_d1", 32'(mem_read_data), 32'h11);
      rd_issue(8'h02); tick(); idle();
      chk("t2_v2", 32'(mem_read_valid), 32'd1);
      chk("t2_d2", 32'(mem_read_data), 32'h22);
      tick();
      chk("t2_v3", 32'(mem_read_valid), 32'd1);
      chk("t2_d3", 32'(mem_read_data), 32'h33);
      tick();
      chk("t2_v4", 32'(mem_read_valid), 32'd0);
      chk("t2_rcnt", read_count, 32'd4);

      // 3: write after read does not disturb the in-flight read
      rd_issue(8'h20); tick();
      idle(); mem_addr = 8'h20; mem_write_data = 8'hFF; mem_write_enable = 1'b1;
      tick(); idle();
      chk("t3_v", 32'(mem_read_valid), 32'd1);
      chk("t3_old", 32'(mem_read_data), 32'h01);
      rd_issue(8'h20); tick(); idle(); tick();
      chk("t3_v2", 32'(mem_read_valid), 32'd1);
      chk("t3_new", 32'(mem_read_data), 32'hFF);
      chk("t3_wcnt", write_count, 32'd6);

      // 4: simultaneous read and write
      idle(); mem_addr = 8'h30; mem_write_data = 8'h77;
      mem_read_enable = 1'b1; mem_write_enable = 1'b1;
      tick(); idle();
      chk("t4_err", 32'(mem_error), 32'd1);
      chk("t4_ecnt", error_count, 32'd1);
      chk("t4_rcnt", read_count, 32'd6);
      chk("t4_wcnt", write_count, 32'd7);
      tick();
      chk("t4_err_pulse", 32'(mem_error), 32'd0);
      chk("t4_nov1", 32'(mem_read_valid), 32'd0);
      tick();
      chk("t4_nov2", 32'(mem_read_valid), 32'd0);
      rd_issue(8'h30); tick(); idle(); tick();
      chk("t4_v", 32'(mem_read_valid), 32'd1);
      chk("t4_data", 32'(mem_read_data), 32'h77);

      // 5: bulk clear; a read and a second clear_start during CLEAR
      lowcnt = 0;
      idle(); clear_start = 1'b1; tick(); idle();
      chk("t5_ready0", 32'(mem_ready), 32'd0);
      if (!mem_ready) lowcnt++;
      rd_issue(8'h10); tick(); idle();
      if (!mem_ready) lowcnt++;
      chk("t5_err", 32'(mem_error), 32'd1);
      chk("t5_ecnt", error_count, 32'd2);
      chk("t5_rcnt", read_count, 32'd7);
      clear_start = 1'b1; tick(); idle();
      if (!mem_ready) lowcnt++;
      chk("t5_nov", 32'(mem_read_valid), 32'd0);
      for (int g = 0; g < 400; g++) begin
         tick();
         if (mem_ready) break;
         lowcnt++;
      end
      chk("t5_ready_back", 32'(mem_ready), 32'd1);
      chk("t5_lowcnt", 32'(lowcnt), 32'd256);
      chk("t5_ecnt_after", error_count, 32'd2);
      rd_issue(8'h10); tick();
      rd_issue(8'h30); tick(); idle();
      chk("t5_d10", 32'(mem_read_data), 32'h00);
      chk("t5_v10", 32'(mem_read_valid), 32'd1);
      tick();
      chk("t5_d30", 32'(mem_read_data), 32'h00);
      chk("t5_v30", 32'(mem_read_valid), 32'd1);

      // 6: reset one cycle after a read flushes it; memory survives
      wr(8'h40, 8'hA5);
      rd_issue(8'h40); tick(); idle();
      rst = 1'b1; tick();
      chk("t6_v_rst", 32'(mem_read_valid), 32'd0);
      chk("t6_rcnt", read_count, 32'd0);
      chk("t6_wcnt", write_count, 32'd0);
      chk("t6_ecnt", error_count, 32'd0);
      chk("t6_ready", 32'(mem_ready), 32'd0);
      rst = 1'b0; tick();
      chk("t6_v_after", 32'(mem_read_valid), 32'd0);
      chk("t6_ready1", 32'(mem_ready), 32'd1);
      tick();
      chk("t6_v_after2", 32'(mem_read_valid), 32'd0);
      rd_issue(8'h40); tick(); idle(); tick();
      chk("t6_v", 32'(mem_read_valid), 32'd1);
      chk("t6_preserved", 32'(mem_read_data), 32'hA5);
      chk("t6_rcnt1", read_count, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
